multi_blinker: RTL and testbench
================================

MULTI_BLINKER -- requirements
Module: multi_blinker

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent LED channels (1..16).
REQ-002 Parameter TICK_DIV, default 100000, clk cycles per blink tick (>=2).
REQ-003 Parameter CNT_W, default 10, width of period and duty fields in ticks.
REQ-004 Port clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port cfg_we  input  1  one-cycle configuration write strobe.
REQ-007 Port cfg_ch  input  clog2(NUM_CH) (min 1)  channel index for the write.
REQ-008 Port cfg_mode  input  2  00 OFF, 01 ON, 10 BLINK, 11 ONESHOT.
REQ-009 Port cfg_period  input  CNT_W  blink period in ticks.
REQ-010 Port cfg_duty  input  CNT_W  on-time in ticks.
REQ-011 Port sync  input  1  one-cycle strobe realigning all channels.
REQ-012 Port led  output  NUM_CH  registered LED drive, bit i = channel i.
REQ-013 Port tick  output  1  one-cycle pulse per blink tick, for observation.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high exactly in the cycle the count equals TICK_DIV-1.
REQ-015 Each channel SHALL hold mode, period, duty, and a CNT_W phase counter.
REQ-016 Phase SHALL advance by 1 on each tick and wrap to 0 when it equals eff_period-1; eff_period = max(period,1).
REQ-017 led[i] SHALL be registered: value in cycle n+1 is computed from state in cycle n (one-cycle latency).
REQ-018 OFF: led[i]=0; ON: led[i]=1; phase is held at 0 in both.
REQ-019 BLINK: led[i] = (phase < duty); duty=0 gives constant 0; duty>=eff_period gives constant 1.
REQ-020 ONESHOT: led[i] = (phase < duty); on the tick where phase reaches duty-1 (or immediately if duty=0), mode SHALL revert to OFF; no wrap.
REQ-021 A write with cfg_ch < NUM_CH SHALL load mode/period/duty and clear that channel's phase in the same edge; cfg_ch >= NUM_CH SHALL be ignored.
REQ-022 Write and tick in the same cycle on the same channel: the write wins; the phase is 0 after the edge.
REQ-023 sync SHALL clear the prescaler and every channel's phase; mode/period/duty are kept.
REQ-024 sync with cfg_we in the same cycle: both take effect; the written channel is loaded with phase 0.
REQ-025 Changing mode from ONESHOT to another mode mid-pulse SHALL abort the pulse with no residual state.

Reset
REQ-026 While rst=1, led=0, tick=0, prescaler=0, and all phases=0. Every mode SHALL be OFF, and period and duty SHALL be 0.
REQ-027 Reset assertion mid-pulse SHALL force led=0 asynchronously. The first tick after release SHALL occur TICK_DIV cycles later.

Structure
REQ-028 Mode encodings (MODE_OFF/ON/BLINK/ONESHOT) SHALL live in the shared package blinker_pkg.
REQ-029 Per-channel logic SHALL be one sub-module blink_channel, instantiated NUM_CH times by generate. The top level SHALL hold the prescaler and write decode.

Verification (NUM_CH=2, TICK_DIV=4, CNT_W=4)
REQ-030 Assert rst for 5 cycles, then release -> led=00 throughout; first tick on the 4th cycle after release.
REQ-031 Write ch0 BLINK period=4 duty=2 -> led[0] high 8 cycles, then low 8 cycles, repeating; first rise one cycle after the write.
REQ-032 Write ch1 ONESHOT duty=3 -> led[1] high for 12 cycles, then low permanently; ch0 unaffected.
REQ-033 Write BLINK duty=0 -> constant 0. Write BLINK duty=5 period=4 -> constant 1. Write cfg_ch=3 -> no change.
REQ-034 Two channels in BLINK with offset phases, then sync -> both phases 0; led edges coincide thereafter.
REQ-035 Assert rst mid-BLINK while led[0]=1 -> led[0]=0 before the next clk edge; stays 0 after release until rewritten.

Source files
------------

// File: rtl/blinker_pkg.sv
// ---------------------------------------------------------------------------
// blinker_pkg
// Shared definitions for the multi-channel LED blinker.
//   mode_e    : per-channel operating mode (OFF / ON / BLINK / ONESHOT)
//   MODE_W    : width of the mode field on the configuration port
//   idx_width : width of a channel-index field for a given channel count,
//               never less than one bit so a single-channel build still
//               has a legal port.
// ---------------------------------------------------------------------------
package blinker_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blink_channel.sv
// ---------------------------------------------------------------------------
// blink_channel
// One independent LED channel: holds its mode, period, duty and phase
// counter, and produces a registered LED drive.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset (everything to zero / OFF)
//   tick      in   one-cycle blink tick from the shared prescaler
//   sync      in   one-cycle strobe clearing the phase counter
//   wr_en     in   configuration write addressed to this channel
//   wr_mode   in   mode to load
//   wr_period in   period (ticks) to load
//   wr_duty   in   on-time (ticks) to load
//   led       out  registered LED drive
// ---------------------------------------------------------------------------
module blink_channel
    import blinker_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             sync,
    input  logic             wr_en,
    input  mode_e            wr_mode,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_duty,
    output logic             led
);

    mode_e            mode_q,   mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q,   duty_d;
    logic [CNT_W-1:0] phase_q,  phase_d;
    logic             led_q,    led_d;

    // Last phase value of a blink cycle. A period of 0 behaves as 1,
    // so the phase simply stays at 0.
    logic [CNT_W-1:0] blink_last;
    // Last phase value of a one-shot pulse (only meaningful when duty != 0).
    logic [CNT_W-1:0] shot_last;

    always_comb begin
        blink_last = (period_q == '0) ? '0 : (period_q - CNT_W'(1));
        shot_last  = duty_q - CNT_W'(1);
    end

    // Next-state logic. Priority: write, then sync, then tick-driven advance.
    // A write always lands with phase 0, so a write that coincides with a
    // tick or a sync still starts the new configuration cleanly.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        phase_d  = phase_q;

        if (wr_en) begin
            mode_d   = wr_mode;
            period_d = wr_period;
            duty_d   = wr_duty;
            phase_d  = '0;
        end else if (sync) begin
            phase_d = '0;
        end else begin
            case (mode_q)
                MODE_BLINK: begin
                    if (tick) begin
                        // >= rather than == keeps the counter bounded even
                        // if the phase were ever beyond the period.
                        phase_d = (phase_q >= blink_last) ? '0 : (phase_q + CNT_W'(1));
                    end
                end
                MODE_ONESHOT: begin
                    if (duty_q == '0) begin
                        // Zero-length pulse: nothing to show, drop out now.
                        mode_d  = MODE_OFF;
                        phase_d = '0;
                    end else if (tick) begin
                        if (phase_q >= shot_last) begin
                            mode_d  = MODE_OFF;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    // OFF and ON keep the phase parked at zero.
                    phase_d = '0;
                end
            endcase
        end
    end

    // LED value is a function of the current state; registering it gives
    // the one-cycle output latency.
    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_ON:      led_d = 1'b1;
            MODE_BLINK:   led_d = (phase_q < duty_q);
            MODE_ONESHOT: led_d = (phase_q < duty_q);
            default:      led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            period_q <= '0;
            duty_q   <= '0;
            phase_q  <= '0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/multi_blinker.sv
// ---------------------------------------------------------------------------
// multi_blinker
// NUM_CH independent LED blinkers sharing one tick prescaler.
//
// Parameters
//   NUM_CH   number of channels (1..16)
//   TICK_DIV clk cycles per blink tick (>= 2)
//   CNT_W    width of the period / duty / phase fields
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   cfg_we     in   one-cycle configuration write strobe
//   cfg_ch     in   target channel; indices >= NUM_CH are ignored
//   cfg_mode   in   00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
//   cfg_period in   blink period in ticks
//   cfg_duty   in   on-time in ticks
//   sync       in   one-cycle strobe: restart prescaler and all phases
//   led        out  registered LED drive, bit i = channel i
//   tick       out  one-cycle pulse per blink tick
// ---------------------------------------------------------------------------
module multi_blinker
    import blinker_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int TICK_DIV = 100000,
    parameter  int CNT_W    = 10,
    localparam int CH_W     = idx_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic              sync,
    output logic [NUM_CH-1:0] led,
    output logic              tick
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // ---------------------------------------------------------------
    // Prescaler: 0 .. TICK_DIV-1, tick decoded from the terminal count.
    // ---------------------------------------------------------------
    logic [PRE_W-1:0] cnt_q, cnt_d;
    logic             tick_now;

    always_comb begin
        tick_now = (cnt_q == PRE_LAST);
        if (sync || tick_now) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = tick_now;

    // ---------------------------------------------------------------
    // Write decode and channel array. An out-of-range cfg_ch matches
    // no channel, so the write is silently dropped.
    // ---------------------------------------------------------------
    logic [NUM_CH-1:0] wr_en;
    mode_e             wr_mode;

    assign wr_mode = mode_e'(cfg_mode);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_en[gi] = cfg_we && (cfg_ch == CH_W'(gi));

            blink_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .tick      (tick_now),
                .sync      (sync),
                .wr_en     (wr_en[gi]),
                .wr_mode   (wr_mode),
                .wr_period (cfg_period),
                .wr_duty   (cfg_duty),
                .led       (led[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_blinker.sv
// ---------------------------------------------------------------------------
// tb_multi_blinker
// Directed bench for multi_blinker (NUM_CH=2, TICK_DIV=4, CNT_W=4), plus a
// 3-channel instance whose 2-bit channel index can express an out-of-range
// channel number (3).
// ---------------------------------------------------------------------------
module tb_multi_blinker;
    import blinker_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [0:0] cfg_ch = 1'b0;
    logic [1:0] cfg_mode = 2'b00;
    logic [3:0] cfg_period = 4'd0;
    logic [3:0] cfg_duty = 4'd0;
    logic       sync = 1'b0;
    logic [1:0] led;
    logic       tick;

    logic       we3 = 1'b0;
    logic [1:0] ch3 = 2'd0;
    logic       sync3 = 1'b0;
    logic [2:0] led3;
    logic       tick3;

    int n_assert = 0;
    int n_fail   = 0;

    multi_blinker #(
        .NUM_CH   (2),
        .TICK_DIV (4),
        .CNT_W    (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .sync       (sync),
        .led        (led),
        .tick       (tick)
    );

    multi_blinker #(
        .NUM_CH   (3),
        .TICK_DIV (4),
        .CNT_W    (4)
    ) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (we3),
        .cfg_ch     (ch3),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .sync       (sync3),
        .led        (led3),
        .tick       (tick3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a write at the current falling edge; returns at the next falling
    // edge, i.e. just after the write has been loaded.
    task automatic wr(input logic ch, input logic [1:0] m, input logic [3:0] p, input logic [3:0] d);
        cfg_ch     = ch;
        cfg_mode   = m;
        cfg_period = p;
        cfg_duty   = d;
        cfg_we     = 1'b1;
        @(negedge clk);
        cfg_we     = 1'b0;
    endtask

    // BLINK period=4 duty=2 with TICK_DIV=4, k = falling edges since the
    // edge that started the channel at phase 0 with the prescaler at 0:
    // LED high for k=1..8, low for 9..16, and so on.
    function automatic logic blink_exp(input int k);
        return (k >= 1) && ((((k - 1) / 8) % 2) == 0);
    endfunction

    initial begin
        // ---------------- reset ----------------
        #2 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rst_led c%0d", i), 32'(led), 32'd0);
            check($sformatf("rst_tick c%0d", i), 32'(tick), 32'd0);
            check($sformatf("rst_led3 c%0d", i), 32'(led3), 32'd0);
        end
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("first_tick j%0d", j), 32'(tick), 32'(j == 3));
            check($sformatf("idle_led j%0d", j), 32'(led), 32'd0);
            if (j < 3) @(negedge clk);
        end

        // ---------------- BLINK ch0 (written in a tick cycle), ONESHOT ch1 ----------------
        wr(1'b0, MODE_BLINK, 4'd4, 4'd2);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("blink0 k%0d", k), 32'(led[0]), 32'(blink_exp(k)));
            check($sformatf("shot1 k%0d", k), 32'(led[1]), 32'((k >= 5) && (k <= 16)));
            check($sformatf("tick k%0d", k), 32'(tick), 32'((k % 4) == 3));
            if (k == 3) begin
                cfg_ch     = 1'b1;
                cfg_mode   = MODE_ONESHOT;
                cfg_period = 4'd0;
                cfg_duty   = 4'd3;
                cfg_we     = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge clk);
        end

        // ---------------- duty boundaries ----------------
        wr(1'b0, MODE_BLINK, 4'd4, 4'd0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("duty0 c%0d", i), 32'(led[0]), 32'd0);
            @(negedge clk);
        end
        wr(1'b0, MODE_BLINK, 4'd4, 4'd5);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("duty5 c%0d", i), 32'(led[0]), 32'd1);
            @(negedge clk);
        end
        wr(1'b1, MODE_ONESHOT, 4'd4, 4'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("shot_duty0 c%0d", i), 32'(led[1]), 32'd0);
            @(negedge clk);
        end

        // ---------------- sync with simultaneous write ----------------
        wr(1'b0, MODE_BLINK, 4'd4, 4'd2);
        repeat (6) @(negedge clk);
        cfg_ch     = 1'b1;
        cfg_mode   = MODE_BLINK;
        cfg_period = 4'd4;
        cfg_duty   = 4'd2;
        cfg_we     = 1'b1;
        sync       = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        sync   = 1'b0;
        for (int k = 0; k < 36; k++) begin
            if (k >= 1) begin
                check($sformatf("sync_led0 k%0d", k), 32'(led[0]), 32'(blink_exp(k)));
                check($sformatf("sync_led1 k%0d", k), 32'(led[1]), 32'(blink_exp(k)));
            end
            check($sformatf("sync_tick k%0d", k), 32'(tick), 32'((k % 4) == 3));
            if (k < 35) @(negedge clk);
        end

        // ---------------- asynchronous reset while led[0] is high ----------------
        check("pre_rst_led0", 32'(led[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_led", 32'(led), 32'd0);
        @(negedge clk);
        check("rst_hold_led", 32'(led), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            check($sformatf("post_rst_led j%0d", j), 32'(led), 32'd0);
            check($sformatf("post_rst_tick j%0d", j), 32'(tick), 32'((j % 4) == 3));
            @(negedge clk);
        end
        wr(1'b0, MODE_ON, 4'd0, 4'd0);
        check("on_latency", 32'(led[0]), 32'd0);
        @(negedge clk);
        check("on_led0", 32'(led), 32'b01);

        // ---------------- out-of-range channel index (3-channel instance) ----------------
        ch3      = 2'd3;
        cfg_mode = MODE_ON;
        we3      = 1'b1;
        @(negedge clk);
        we3 = 1'b0;
        repeat (2) @(negedge clk);
        check("ch3_ignored", 32'(led3), 32'd0);
        ch3 = 2'd2;
        we3 = 1'b1;
        @(negedge clk);
        we3 = 1'b0;
        repeat (2) @(negedge clk);
        check("ch2_on", 32'(led3), 32'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
